// File: rtl/n64_frame_assembler.sv
// N64 controller response assembler: turns decoded data-line symbols into a FRAME_BITS word,
// checks the stop bit and aborts on inter-symbol timeout. Optional error counter: N64_ERR_CNT_EN.
module n64_frame_assembler #(
  parameter int FRAME_BITS     = 32,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic [1:0]            Sym_In,
  output logic [FRAME_BITS-1:0] Frame_Data,
  output logic                  Frame_Valid,
  output logic                  Frame_Err,
  output logic                  Busy,
  output logic [1:0]            Dbg_State
`ifdef N64_ERR_CNT_EN
  ,
  output logic [7:0]            Err_Count
`endif
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_STOP    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [1:0]            sym_prev_q, sym_prev_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  sym_ok, accept, sym_bit;

  // Handshake: a symbol is taken on the edge where a valid code follows a quiet (00) cycle;
  // holding a code or switching 01<->10 directly never produces a second acceptance.
  assign sym_ok     = (Sym_In == 2'b01) || (Sym_In == 2'b10);
  assign accept     = Enable && sym_ok && (sym_prev_q == 2'b00);
  assign sym_bit    = (Sym_In == 2'b01);
  assign sym_prev_d = (Sym_In == 2'b11) ? 2'b00 : Sym_In;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (!Enable) begin
      state_d = S_IDLE;
      shift_d = '0;
      cnt_d   = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            shift_d = {{(FRAME_BITS-1){1'b0}}, sym_bit};
            cnt_d   = CW'(1);
            tmo_d   = '0;
            state_d = S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (accept) begin
            shift_d = {shift_q[FRAME_BITS-2:0], sym_bit};
            cnt_d   = cnt_q + CW'(1);
            tmo_d   = '0;
            if (cnt_d == CW'(FRAME_BITS)) state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (accept) begin
            if (sym_bit) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = S_IDLE;
            shift_d = '0;
            cnt_d   = '0;
            tmo_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // An accepted symbol in the would-be timeout cycle takes priority over the abort.
      if ((state_q != S_IDLE) && !accept) begin
        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          shift_d = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      sym_prev_q <= 2'b00;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      sym_prev_q <= sym_prev_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

`ifdef N64_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) err_cnt_q <= 8'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign Err_Count = err_cnt_q;
`endif

  assign Frame_Data  = data_q;
  assign Frame_Valid = valid_q;
  assign Frame_Err   = err_q;
  assign Busy        = (state_q != S_IDLE);
  assign Dbg_State   = state_q;

endmodule

// File: tb/tb_n64_frame_assembler.sv
// Directed bench for n64_frame_assembler: a table of whole frames plus hand-written
// sequences for reset, timeout, held/illegal symbols and enable drop.
module tb_n64_frame_assembler;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Enable;
  logic [1:0]  Sym_In;
  logic [31:0] Frame_Data;
  logic        Frame_Valid;
  logic        Frame_Err;
  logic        Busy;
  logic [1:0]  Dbg_State;
`ifdef N64_ERR_CNT_EN
  logic [7:0]  Err_Count;
`endif

  n64_frame_assembler #(.FRAME_BITS(32), .TIMEOUT_CYCLES(200)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .Enable      (Enable),
    .Sym_In      (Sym_In),
    .Frame_Data  (Frame_Data),
    .Frame_Valid (Frame_Valid),
    .Frame_Err   (Frame_Err),
    .Busy        (Busy),
    .Dbg_State   (Dbg_State)
`ifdef N64_ERR_CNT_EN
    ,
    .Err_Count   (Err_Count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int chk_cnt  = 0;
  int v_pulses = 0;
  int e_pulses = 0;
  int exp_errs = 0;
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (Frame_Valid === 1'b1) v_pulses++;
    if (Frame_Err === 1'b1)   e_pulses++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [1:0] code, input int hold, input int gap);
    Sym_In = code;
    repeat (hold) step();
    Sym_In = 2'b00;
    repeat (gap) step();
  endtask

  task automatic send_bits(input logic [31:0] w, input int hi, input int n,
                           input int hold, input int gap);
    for (int i = 0; i < n; i++) send_sym(w[hi-i] ? 2'b01 : 2'b10, hold, gap);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [1:0]  stop;
    int          hold;
    int          gap;
    logic [31:0] exp_data;
    logic        exp_valid;
    logic        exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int v0, e0;
    v0 = v_pulses;
    e0 = e_pulses;
    send_bits(v.word, 31, 32, v.hold, v.gap);
    check1({tag, "_busy_in_stop"}, Busy, 1'b1);
    Sym_In = v.stop;
    step();
    check1({tag, "_valid_strobe"}, Frame_Valid, v.exp_valid);
    check1({tag, "_err_strobe"}, Frame_Err, v.exp_err);
    check1({tag, "_busy_drop"}, Busy, 1'b0);
    repeat (v.hold - 1) step();
    Sym_In = 2'b00;
    repeat (2) step();
    exp_q.push_back(v.exp_data);
    check({tag, "_data"}, Frame_Data, exp_q.pop_front());
    check({tag, "_valid_pulses"}, v_pulses - v0, v.exp_valid ? 32'd1 : 32'd0);
    check({tag, "_err_pulses"}, e_pulses - e0, v.exp_err ? 32'd1 : 32'd0);
    if (v.exp_err) exp_errs++;
  endtask

  task automatic tmo_abort(input int nbits, input string tag);
    int e0;
    e0 = e_pulses;
    send_bits(32'h5A5A_5A5A, 31, nbits, 2, 1);
    repeat (205) step();
    check({tag, "_err_pulses"}, e_pulses - e0, 32'd1);
    check1({tag, "_busy"}, Busy, 1'b0);
    exp_errs++;
  endtask

  // ---------------- stimulus ----------------
  vec_t vec[6];

  initial begin
    int v0, e0, first;

    vec[0] = '{32'h80C0_1234, 2'b01, 40, 5, 32'h80C0_1234, 1'b1, 1'b0};
    vec[1] = '{32'h80C0_1234, 2'b10, 3,  2, 32'h80C0_1234, 1'b0, 1'b1};
    vec[2] = '{32'hFFFF_FFFF, 2'b01, 1,  1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vec[3] = '{32'h0000_0000, 2'b01, 2,  1, 32'h0000_0000, 1'b1, 1'b0};
    vec[4] = '{32'hA5A5_5A5A, 2'b01, 1,  2, 32'hA5A5_5A5A, 1'b1, 1'b0};
    vec[5] = '{32'h1234_5678, 2'b10, 2,  1, 32'hA5A5_5A5A, 1'b0, 1'b1};

    Reset  = 1'b1;
    Enable = 1'b1;
    Sym_In = 2'b00;
    repeat (3) step();
    check("rst_data", Frame_Data, 32'h0);
    check1("rst_valid", Frame_Valid, 1'b0);
    check1("rst_err", Frame_Err, 1'b0);
    check1("rst_busy", Busy, 1'b0);
`ifdef N64_ERR_CNT_EN
    check("rst_err_count", {24'h0, Err_Count}, 32'h0);
`endif
    Reset = 1'b0;
    step();

    for (int k = 0; k < 6; k++) run_vec(vec[k], $sformatf("vec%0d", k));

    // Reset in the middle of a frame
    v0 = v_pulses;
    e0 = e_pulses;
    send_bits(32'hFFFF_0000, 31, 10, 2, 2);
    check1("midrst_busy_before", Busy, 1'b1);
    @(posedge clk);
    #3 Reset = 1'b1;
    #1;
    check1("midrst_busy", Busy, 1'b0);
    check("midrst_data", Frame_Data, 32'h0);
    step();
    step();
    Reset = 1'b0;
    step();
    check("midrst_no_strobes", (v_pulses - v0) + (e_pulses - e0), 32'd0);
    exp_errs = 0;
    run_vec('{32'hFEDC_BA98, 2'b01, 2, 2, 32'hFEDC_BA98, 1'b1, 1'b0}, "after_rst");

    // Timeout after 20 symbols: error exactly 200 edges after the last acceptance
    e0 = e_pulses;
    send_bits(32'h0ABC_DE12, 31, 19, 2, 2);
    Sym_In = 2'b01;
    step();
    Sym_In = 2'b00;
    first = -1;
    for (int k = 1; k <= 300 && first < 0; k++) begin
      step();
      if (Frame_Err === 1'b1) first = k;
    end
    check("timeout_cycle", first, 32'd200);
    check1("timeout_busy", Busy, 1'b0);
    step();
    check1("timeout_single_pulse", Frame_Err, 1'b0);
    check("timeout_err_pulses", e_pulses - e0, 32'd1);
    check("timeout_data_kept", Frame_Data, 32'hFEDC_BA98);
    exp_errs++;
    run_vec('{32'h0F0F_F0F0, 2'b01, 3, 3, 32'h0F0F_F0F0, 1'b1, 1'b0}, "after_tmo");

    // Enable dropped after 10 bits, symbols ignored while disabled
    v0 = v_pulses;
    e0 = e_pulses;
    send_bits(32'hCAFE_BABE, 31, 10, 2, 2);
    check1("endrop_busy_before", Busy, 1'b1);
    Enable = 1'b0;
    step();
    check1("endrop_busy", Busy, 1'b0);
    send_sym(2'b01, 3, 2);
    check1("endrop_ignored", Busy, 1'b0);
    Enable = 1'b1;
    step();
    check("endrop_no_strobes", (v_pulses - v0) + (e_pulses - e0), 32'd0);
    check("endrop_data_kept", Frame_Data, 32'h0F0F_F0F0);
    run_vec('{32'h1357_9BDF, 2'b01, 2, 1, 32'h1357_9BDF, 1'b1, 1'b0}, "after_endrop");

    // Held 01, direct 01->10 and code 11 together contribute a single '1' bit
    v0 = v_pulses;
    send_sym(2'b01, 100, 0);
    send_sym(2'b10, 5, 3);
    send_sym(2'b11, 5, 3);
    check1("held_busy", Busy, 1'b1);
    send_bits(32'hC3A5_0F1E, 30, 31, 2, 2);
    check1("held_busy_in_stop", Busy, 1'b1);
    Sym_In = 2'b01;
    step();
    check1("held_valid_strobe", Frame_Valid, 1'b1);
    Sym_In = 2'b00;
    repeat (2) step();
    check("held_data", Frame_Data, 32'hC3A5_0F1E);
    check("held_valid_pulses", v_pulses - v0, 32'd1);

    // Two more timeouts (three since the mid-frame reset)
    tmo_abort(1, "tmo_a");
    tmo_abort(31, "tmo_b");
`ifdef N64_ERR_CNT_EN
    check("err_count", {24'h0, Err_Count}, exp_errs);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
